// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- shared iterative multiply / divide engine for the multicycle
// datapath. One bit of work per clock: radix-2 shift-add for multiply,
// restoring division for divide. Results land in hi/lo and hold until the next
// completed (non divide-by-zero) operation.
//
// Parameters
//   WIDTH      operand width, 4..64
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin an operation (only looked at in IDLE)
//   op         0 = multiply, 1 = divide (sampled with start)
//   is_signed  two's-complement operands (sampled with start)
//   a, b       multiplicand/dividend, multiplier/divisor (sampled with start)
//   hi, lo     multiply: {hi,lo} = product; divide: hi = remainder, lo = quotient
//   busy       high in every non-IDLE state
//   done       one-cycle completion pulse
//   divz       one-cycle divide-by-zero pulse, coincident with done
//
// Build option
//   MULDIV_SIGNED_EN  when defined, is_signed is honoured (abs-value prep and
//                     result negation are built). Otherwise every operation is
//                     unsigned and is_signed is ignored.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divz
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;      // {upper, lower}: product, or {remainder, quotient}
    logic [CW-1:0]      cnt_q;
    logic               divz_q;     // divide-by-zero detected in PREP
    logic               neg_p_q;    // negate product / quotient in FIX
    logic               neg_r_q;    // negate remainder in FIX

`ifdef MULDIV_SIGNED_EN
    logic               sgn_q;
`else
    logic               unused_sgn;
    assign unused_sgn = is_signed;
`endif

    // Magnitudes fed to the unsigned core
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             neg_p_d, neg_r_d;

    always_comb begin
        a_abs   = a_q;
        b_abs   = b_q;
        neg_p_d = 1'b0;
        neg_r_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        if (sgn_q) begin
            // The most-negative value maps onto itself, which read as
            // unsigned is exactly its magnitude.
            a_abs   = a_q[WIDTH-1] ? -a_q : a_q;
            b_abs   = b_q[WIDTH-1] ? -b_q : b_q;
            neg_p_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
            neg_r_d = a_q[WIDTH-1];
        end
`endif
    end

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     div_cand;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_acc_d;

    always_comb begin
        // Add multiplier into the upper half when the current LSB is set,
        // then shift the whole accumulator right (carry enters at the top).
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

        // Shift next dividend bit into the partial remainder and try to
        // subtract; the borrow (diff MSB) decides the quotient bit.
        div_cand  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_cand - {1'b0, b_q};
        if (!div_diff[WIDTH])
            div_acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_acc_d = {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Sign-corrected results written to hi/lo when leaving FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

    always_comb begin
        prod_fix = neg_p_q ? -acc_q : acc_q;
        if (!op_q) begin
            fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo_d = prod_fix[WIDTH-1:0];
        end else begin
            fix_hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_lo_d = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            divz_q  <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
`ifdef MULDIV_SIGNED_EN
                        sgn_q   <= is_signed;
`endif
                        busy    <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    b_q     <= b_abs;
                    acc_q   <= {{WIDTH{1'b0}}, a_abs};
                    neg_p_d_apply: begin
                        neg_p_q <= neg_p_d;
                        neg_r_q <= neg_r_d;
                    end
                    cnt_q   <= CW'(WIDTH - 1);
                    if (op_q && (b_q == '0)) begin
                        // Skip the iterations; passing through FIX (which
                        // leaves hi/lo alone) puts done two edges after start.
                        divz_q  <= 1'b1;
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= op_q ? div_acc_d : mul_acc_d;
                    if (cnt_q == '0) state_q <= S_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (!divz_q) begin
                        hi <= fix_hi_d;
                        lo <= fix_lo_d;
                    end
                    done    <= 1'b1;
                    divz    <= divz_q;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    divz    <= 1'b0;
                    divz_q  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a WIDTH=32 and a WIDTH=8 instance, directed cases
// from the datapath use plus randomized operations, all checked against a
// plain-arithmetic reference (integer *, /, %) computed here.
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        st32, op32, sg32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        busy32, done32, divz32;
    logic        st8, op8, sg8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, divz8;

    int vectors = 0;
    int errs    = 0;
    longint unsigned ph32 = 0, pl32 = 0, ph8 = 0, pl8 = 0;
    logic [63:0] got_hi, got_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(st32), .op(op32), .is_signed(sg32),
        .a(a32), .b(b32), .hi(hi32), .lo(lo32),
        .busy(busy32), .done(done32), .divz(divz32)
    );

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(st8), .op(op8), .is_signed(sg8),
        .a(a8), .b(b8), .hi(hi8), .lo(lo8),
        .busy(busy8), .done(done8), .divz(divz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void model(input int w, input bit op_v, input bit sgn_v,
                                  input longint unsigned av, input longint unsigned bv,
                                  input longint unsigned ph, input longint unsigned pl,
                                  output longint unsigned eh, output longint unsigned el,
                                  output bit dz);
        longint unsigned mask = (64'd1 << w) - 1;
        bit     s  = sgn_v & SGN_EN;
        longint sa = (s && av[w-1]) ? longint'(av) - (longint'(1) << w) : longint'(av);
        longint sb = (s && bv[w-1]) ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        longint unsigned p;
        dz = 1'b0;
        if (!op_v) begin
            p  = s ? longint'(sa * sb) : av * bv;
            eh = (p >> w) & mask;
            el = p & mask;
        end else if (bv == 0) begin
            eh = ph; el = pl; dz = 1'b1;
        end else if (s) begin
            el = longint'(sa / sb) & mask;
            eh = longint'(sa % sb) & mask;
        end else begin
            el = (av / bv) & mask;
            eh = (av % bv) & mask;
        end
    endfunction

    // Issue one operation on the chosen instance and check the whole handshake.
    // poke: re-assert start with junk operands at cycles 5 and 20.
    task automatic run(input bit sel8, input bit op_v, input bit sgn_v,
                       input longint unsigned av, input longint unsigned bv, input bit poke);
        int w = sel8 ? 8 : 32;
        int cyc;
        longint unsigned eh, el;
        bit dz;
        logic dn;
        model(w, op_v, sgn_v, av, bv, sel8 ? ph8 : ph32, sel8 ? pl8 : pl32, eh, el, dz);
        @(negedge clk);
        if (sel8) begin op8 = op_v; sg8 = sgn_v; a8 = av[7:0]; b8 = bv[7:0]; st8 = 1'b1; end
        else      begin op32 = op_v; sg32 = sgn_v; a32 = av[31:0]; b32 = bv[31:0]; st32 = 1'b1; end
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        st8 = 1'b0; st32 = 1'b0;
        check("busy_after_start", sel8 ? busy8 : busy32, 1'b1);
        dn = sel8 ? done8 : done32;
        while (!dn && cyc < w + 20) begin
            if (poke && !sel8 && (cyc == 5 || cyc == 20)) begin
                st32 = 1'b1; a32 = $urandom; b32 = $urandom; op32 = ~op_v;
            end else begin
                st32 = 1'b0;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            dn = sel8 ? done8 : done32;
        end
        st32 = 1'b0;
        check("done_seen", dn, 1'b1);
        check("latency", 64'(cyc), dz ? 64'd3 : 64'(w + 3));
        got_hi = sel8 ? 64'(hi8) : 64'(hi32);
        got_lo = sel8 ? 64'(lo8) : 64'(lo32);
        check("hi", got_hi, eh);
        check("lo", got_lo, el);
        check("divz", sel8 ? divz8 : divz32, dz);
        check("busy_in_done", sel8 ? busy8 : busy32, 1'b1);
        @(negedge clk);
        check("done_pulse_end", sel8 ? done8 : done32, 1'b0);
        check("busy_end", sel8 ? busy8 : busy32, 1'b0);
        if (sel8) begin ph8 = eh; pl8 = el; end
        else      begin ph32 = eh; pl32 = el; end
    endtask

    initial begin
        bit sawdone;
        longint unsigned ra, rb;
        reset = 1'b1;
        st32 = 0; op32 = 0; sg32 = 0; a32 = 0; b32 = 0;
        st8 = 0; op8 = 0; sg8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi32, 32'h0);
        check("rst_lo", lo32, 32'h0);
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_divz", divz32, 1'b0);
        check("rst_hi8", hi8, 8'h0);
        reset = 1'b0;

        run(0, 0, 0, 6, 7, 0);
        check("tp_6x7_hi", got_hi, 64'h0);
        check("tp_6x7_lo", got_lo, 64'h2A);

        run(0, 0, 1, 32'hFFFFFFFD, 5, 0);
        check("tp_m3x5_hi", got_hi, SGN_EN ? 64'hFFFFFFFF : 64'h4);
        check("tp_m3x5_lo", got_lo, 64'hFFFFFFF1);

        run(0, 1, 1, 32'hFFFFFFF9, 2, 0);
        if (SGN_EN) begin
            check("tp_m7d2_lo", got_lo, 64'hFFFFFFFD);
            check("tp_m7d2_hi", got_hi, 64'hFFFFFFFF);
        end
        run(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 0);
        if (SGN_EN) begin
            check("tp_ovf_lo", got_lo, 64'h80000000);
            check("tp_ovf_hi", got_hi, 64'h0);
        end

        run(0, 1, 0, 95, 10, 0);
        check("tp_95d10_hi", got_hi, 64'd5);
        check("tp_95d10_lo", got_lo, 64'd9);
        run(0, 1, 0, 100, 0, 0);
        check("tp_divz_hi", got_hi, 64'd5);
        check("tp_divz_lo", got_lo, 64'd9);

        // start while busy must be ignored
        run(0, 0, 0, 64'($urandom), 64'($urandom), 1);

        for (int i = 0; i < 30; i++) begin
            ra = 64'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom);
            if (i % 7 == 3) ra = 64'h80000000;
            if (i % 5 == 2) rb = 64'hFFFFFFFF;
            run(0, 1'($urandom), 1'($urandom), ra, rb, 1'($urandom));
        end

        run(1, 0, 0, 8'hFF, 8'hFF, 0);
        check("tp_w8_hi", got_hi, 64'hFE);
        check("tp_w8_lo", got_lo, 64'h01);
        run(1, 1, 0, 200, 7, 0);
        check("tp_w8d_lo", got_lo, 64'd28);
        check("tp_w8d_hi", got_hi, 64'd4);
        for (int i = 0; i < 12; i++)
            run(1, 1'($urandom), 1'($urandom), 64'($urandom_range(0, 255)),
                64'($urandom_range(0, 255)), 0);

        // Reset in the middle of a divide
        @(negedge clk);
        op32 = 1'b1; sg32 = 1'b0; a32 = $urandom; b32 = 32'd3; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy32, 1'b0);
        check("midrst_done", done32, 1'b0);
        check("midrst_hi", hi32, 32'h0);
        check("midrst_lo", lo32, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sawdone = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (done32 || busy32) sawdone = 1'b1;
        end
        check("midrst_no_done", sawdone, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
